hex_display_ctrl: RTL
=====================

# hex_display_ctrl

Registered, parametrised multi-digit 7-segment hex display controller for the DE-series HEX outputs. Captures a packed hex value on a load strobe and drives NUM_DIGITS active-low digits. Adds timed blinking and circular scrolling of the digit string. Sits between datapath/status registers and the board HEX0..HEXn pins, replacing per-digit combinational decoders.

## Interface
- NUM_DIGITS, 6, number of digits driven; legal 1..8
- BLINK_DIV, 25000000, clock cycles per blink half-period; legal >= 2
- SCROLL_DIV, 12500000, clock cycles per scroll step; legal >= 2
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- load  in  1  capture data on this edge
- data  in  4*NUM_DIGITS  packed value; nibble i (bits 4i+3:4i) belongs to digit i
- blink_en  in  1  enable blinking
- scroll_en  in  1  enable scrolling
- hex  out  7*NUM_DIGITS  active-low segments; digit i at bits 7i+6:7i; bit 0 = segment a … bit 6 = segment g
- wrap  out  1  one-cycle pulse when the scroll offset wraps N-1 -> 0

## Operation
- Registers: value (4N bits), offset (0..N-1), blink phase (1 = on), blink counter, scroll counter, hex, wrap.
- Load: at an edge with load=1, value <= data, offset <= 0, phase <= on, both counters <= 0.
- Decode (active-low, hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E. Blank digit = 7F.
- Rotation: displayed digit i = value nibble ((i − offset) mod N). Content moves toward higher digit index, i.e. leftward on the board.
- Blink counter: runs only while blink_en=1. Counts 0..BLINK_DIV−1. At terminal count it returns to 0 and phase toggles.
- When blink_en=0: counter is held at 0 and phase is forced to on.
- When blink_en=1 and phase=off: all digits are 7F.
- Scroll counter: runs only while scroll_en=1. Counts 0..SCROLL_DIV−1. At terminal count it returns to 0 and offset increments mod N.
- Wrap: asserted on the cycle after an edge where offset went N−1 -> 0 from a scroll step; otherwise 0.
- When scroll_en=0: scroll counter is held at 0 and offset holds its current value.
- NUM_DIGITS=1: offset is always 0; wrap pulses on every scroll step.
- Priority: reset > load > counter ticks. If a load and a blink or scroll terminal count fall on the same edge, the load wins: no toggle, no increment, no wrap.

## Timing
- Reset values:
  - hex = all 1s (all digits blank)
  - value = 0, offset = 0, phase = on, counters = 0, wrap = 0
- hex is a register computed from current value/offset/phase. Latency is 2 edges: load at edge k -> new value at edge k -> hex updated at edge k+1.
- Phase or offset changes appear on hex one edge after they occur.
- Reset asserted mid-blink or mid-scroll clears everything at that edge. hex is blank during reset. First decoded output appears one edge after reset deasserts (shows value 0).
- No backpressure: load is accepted every cycle; back-to-back loads keep the last value.

## Configuration
- HEXDISP_LZ_BLANK_EN defined: leading-zero blanking.
  - Digits above the most significant nonzero nibble of value are blank (7F).
  - Digit 0 is never blanked; value 0 shows a single "0".
  - The blank mask is computed on unrotated value and rotates with its digits.
  - Blink off-phase still overrides everything.
- HEXDISP_LZ_BLANK_EN undefined: every digit is decoded, leading zeros show as 40.

## Test plan
All with NUM_DIGITS=6, BLINK_DIV=4, SCROLL_DIV=3.
- Reset, then load 24'h12AB3F -> 2 edges later hex digits 0..5 = 0E,30,03,08,24,79; wrap = 0.
- Load 24'h00000A -> digit0 = 08. With HEXDISP_LZ_BLANK_EN, digits 1..5 = 7F; without it, digits 1..5 = 40.
- Load 24'h000005, blink_en=1 -> hex alternates: 4 cycles decoded (digit0=12), 4 cycles all 7F, repeating. Deassert blink_en -> decoded within 1 edge.
- Load 24'h012345, scroll_en=1:
  - after 3 cycles, digits 0..5 show 0,5,4,3,2,1 (40,12,19,30,24,79)
  - wrap pulses once 18 cycles after load, then every 18 cycles
- Load asserted on the same edge as a scroll terminal count -> offset = 0, no wrap pulse, digits show the new data unrotated.
- Assert reset for 1 cycle during blink-off with offset=2 -> hex = all 1s during reset, then decoded 0s with offset 0 and phase on.

Source files
------------

// File: rtl/hex_display_if.sv
// Bundle between a register source and the multi-digit hex display
// controller: load strobe, packed value, mode enables, segment outputs.
interface hex_display_if #(
    parameter int NUM_DIGITS = 6
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   data;
    logic                      blink_en;
    logic                      scroll_en;
    logic [7*NUM_DIGITS-1:0]   hex;
    logic                      wrap;

    modport master (
        output load, data, blink_en, scroll_en,
        input  hex, wrap
    );

    modport slave (
        input  load, data, blink_en, scroll_en,
        output hex, wrap
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// Registered N-digit active-low 7-segment driver with blink and scroll.
// Optional leading-zero blanking: define HEXDISP_LZ_BLANK_EN.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCROLL_DIV = 12500000
) (
    input  logic         clock,
    input  logic         reset,
    hex_display_if.slave bus
);
    localparam int OW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = $clog2(BLINK_DIV);
    localparam int SW = $clog2(SCROLL_DIV);
    localparam logic [OW-1:0] OFF_LAST    = OW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_DIV - 1);

    logic [4*NUM_DIGITS-1:0] value;
    logic [OW-1:0]           offset;
    logic                    phase;
    logic [BW-1:0]           blink_cnt;
    logic [SW-1:0]           scroll_cnt;
    logic [7*NUM_DIGITS-1:0] hex_q;
    logic                    wrap_q;

    logic [7*NUM_DIGITS-1:0] hex_next;
    logic [NUM_DIGITS-1:0]   shown;
    logic [3:0]              nib [NUM_DIGITS];

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Source nibble for display position i: (i - off) mod N.
    function automatic logic [OW-1:0] src_of(input int i,
                                             input logic [OW-1:0] off);
        int s;
        s = i - int'(off);
        if (s < 0) s = s + NUM_DIGITS;
        return OW'(s);
    endfunction

    always_comb begin
        for (int j = 0; j < NUM_DIGITS; j++) begin
            nib[j] = value[4*j +: 4];
        end
    end

`ifdef HEXDISP_LZ_BLANK_EN
    // Mask is per source nibble, so it travels with its digit on rotation.
    always_comb begin
        logic seen;
        seen  = 1'b0;
        shown = '0;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            seen     = seen | (nib[j] != 4'h0);
            shown[j] = seen | (j == 0);
        end
    end
`else
    always_comb begin
        shown = '1;
    end
`endif

    always_comb begin
        hex_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (shown[src_of(i, offset)] && !(bus.blink_en && !phase)) begin
                hex_next[7*i +: 7] = seg(nib[src_of(i, offset)]);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value      <= '0;
            offset     <= '0;
            phase      <= 1'b1;
            blink_cnt  <= '0;
            scroll_cnt <= '0;
            hex_q      <= '1;
            wrap_q     <= 1'b0;
        end else begin
            hex_q  <= hex_next;
            wrap_q <= 1'b0;
            if (bus.load) begin
                value      <= bus.data;
                offset     <= '0;
                phase      <= 1'b1;
                blink_cnt  <= '0;
                scroll_cnt <= '0;
            end else begin
                if (!bus.blink_en) begin
                    blink_cnt <= '0;
                    phase     <= 1'b1;
                end else if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end

                if (!bus.scroll_en) begin
                    scroll_cnt <= '0;
                end else if (scroll_cnt == SCROLL_LAST) begin
                    scroll_cnt <= '0;
                    if (offset == OFF_LAST) begin
                        offset <= '0;
                        wrap_q <= 1'b1;
                    end else begin
                        offset <= offset + OW'(1);
                    end
                end else begin
                    scroll_cnt <= scroll_cnt + SW'(1);
                end
            end
        end
    end

    assign bus.hex  = hex_q;
    assign bus.wrap = wrap_q;
endmodule
